// File: rtl/otter_ifetch.sv
// Instruction fetch stage: issues one memory read per PC request, holds the fetched word for decode.
// Optional OTTER_IFETCH_ALIGN_CHECK_EN: misaligned fetches raise fault instead of issuing a read.
module otter_ifetch #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_addr,
    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    output logic [31:0] ir_addr,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        fault,
    input  logic        fault_clr
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN} state_t;

    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_mem_req;
    logic [31:0] r_mem_addr;
    logic [31:0] r_ir;
    logic [31:0] r_ir_addr;
    logic        r_ir_valid;
    logic        r_fault;
    logic [15:0] r_cnt;

    state_t      w_state_next;
    logic        w_mem_req_next;
    logic [31:0] w_mem_addr_next;
    logic [31:0] w_ir_next;
    logic [31:0] w_ir_addr_next;
    logic        w_ir_valid_next;
    logic        w_fault_set;
    logic [15:0] w_cnt_next;
    logic        w_pc_ready;
    logic        w_issue;
    logic        w_timeout;
    logic        w_misaligned;

`ifdef OTTER_IFETCH_ALIGN_CHECK_EN
    assign w_misaligned = |pc_addr[1:0];
`else
    logic w_unused_lsb;
    assign w_unused_lsb = ^pc_addr[1:0];
    assign w_misaligned = 1'b0;
`endif

    assign w_timeout = (r_cnt == TIMEOUT_M1);

    always_comb begin
        w_state_next    = r_state;
        w_mem_req_next  = 1'b0;
        w_mem_addr_next = r_mem_addr;
        w_ir_next       = r_ir;
        w_ir_addr_next  = r_ir_addr;
        w_ir_valid_next = r_ir_valid;
        w_fault_set     = 1'b0;
        w_cnt_next      = (mem_rvalid || r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
        w_pc_ready      = 1'b0;
        w_issue         = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A redirect wins over a request arriving in the same cycle.
                w_pc_ready = !flush;
                w_issue    = !flush && pc_valid;
            end
            S_WAIT: begin
                if (flush) begin
                    w_state_next = mem_rvalid ? S_IDLE : S_DRAIN;
                    w_cnt_next   = 16'd0;
                end else if (mem_rvalid) begin
                    w_ir_next       = mem_rdata;
                    w_ir_valid_next = 1'b1;
                    w_state_next    = S_HOLD;
                end else if (w_timeout) begin
                    w_fault_set  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    w_ir_valid_next = 1'b0;
                    w_state_next    = S_IDLE;
                end else if (ir_ready) begin
                    w_ir_valid_next = 1'b0;
                    w_pc_ready      = 1'b1;
                    w_issue         = pc_valid;
                    w_state_next    = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (mem_rvalid) begin
                    w_state_next = S_IDLE;
                end else if (w_timeout) begin
                    w_fault_set  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        if (w_issue) begin
            if (w_misaligned) begin
                w_fault_set  = 1'b1;
                w_state_next = S_IDLE;
            end else begin
                w_mem_req_next  = 1'b1;
                w_mem_addr_next = {pc_addr[31:2], 2'b00};
                w_ir_addr_next  = {pc_addr[31:2], 2'b00};
                w_cnt_next      = 16'd0;
                w_state_next    = S_WAIT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'd0;
            r_ir       <= 32'd0;
            r_ir_addr  <= 32'd0;
            r_ir_valid <= 1'b0;
            r_fault    <= 1'b0;
            r_cnt      <= 16'd0;
        end else begin
            r_state    <= w_state_next;
            r_mem_req  <= w_mem_req_next;
            r_mem_addr <= w_mem_addr_next;
            r_ir       <= w_ir_next;
            r_ir_addr  <= w_ir_addr_next;
            r_ir_valid <= w_ir_valid_next;
            // A new fault outranks a simultaneous clear.
            r_fault    <= w_fault_set || (r_fault && !fault_clr);
            r_cnt      <= w_cnt_next;
        end
    end

    assign pc_ready = w_pc_ready;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign ir       = r_ir;
    assign ir_addr  = r_ir_addr;
    assign ir_valid = r_ir_valid;
    assign fault    = r_fault;

endmodule

// File: tb/tb_otter_ifetch.sv
// Directed bench for otter_ifetch with a latency-programmable memory responder and an
// in-order scoreboard of expected {ir_addr, ir} handshakes.
module tb_otter_ifetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_addr = 32'd0;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] ir;
    logic [31:0] ir_addr;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        fault;
    logic        fault_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    logic [63:0] exp_q[$];

    // Memory responder state (deliberately not reset by rst).
    int          lat = 0;
    bit          resp_off = 1'b0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = 32'd0;

    otter_ifetch #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .ir(ir), .ir_addr(ir_addr), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .fault(fault), .fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'h0050_0093;
            32'h300: return 32'hDEAD_BEEF;
            default: return {a[15:0], 16'hC0DE};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_ir(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        if (mem_req && !resp_off) begin
            pend      = 1'b1;
            pend_cnt  = lat;
            pend_data = mem_word(mem_addr);
        end
        if (pend) begin
            if (pend_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_data;
                pend       = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
    end

    // Scoreboard: every decode handshake must match the next expected instruction.
    always @(negedge clk) begin
        #2;
        if (ir_valid && ir_ready) begin
            logic [63:0] e;
            if (exp_q.size() == 0) begin
                check("unexpected_ir", ir, 32'hxxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                pops++;
                $display("IR handshake addr=%h data=%h", ir_addr, ir);
                check("sb_ir_addr", ir_addr, e[63:32]);
                check("sb_ir", ir, e[31:0]);
            end
        end
    end

    initial begin
        int acc;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_pc_ready", {31'd0, pc_ready}, 32'd1);

        // Single fetch, 2-cycle latency, hold while decode stalls
        lat = 0; ir_ready = 1'b0;
        pc_addr = 32'h100; pc_valid = 1'b1;
        expect_ir(32'h100, 32'h0050_0093);
        @(negedge clk);
        pc_valid = 1'b0;
        check("single_mem_req", {31'd0, mem_req}, 32'd1);
        check("single_mem_addr", mem_addr, 32'h100);
        #1 check("wait_pc_ready", {31'd0, pc_ready}, 32'd0);
        @(negedge clk);
        check("single_mem_req_pulse", {31'd0, mem_req}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            check("hold_ir_valid", {31'd0, ir_valid}, 32'd1);
            check("hold_ir", ir, 32'h0050_0093);
            check("hold_ir_addr", ir_addr, 32'h100);
            #1 check("hold_pc_ready", {31'd0, pc_ready}, 32'd0);
            @(negedge clk);
        end
        ir_ready = 1'b1;
        @(negedge clk);
        check("consumed_ir_valid", {31'd0, ir_valid}, 32'd0);

        // Back-to-back fetches with the PC advancing on pc_ready
        acc = 0;
        pc_addr = 32'h0; pc_valid = 1'b1;
        expect_ir(32'h0, mem_word(32'h0));
        expect_ir(32'h4, mem_word(32'h4));
        expect_ir(32'h8, mem_word(32'h8));
        for (int c = 0; c < 30 && acc < 3; c++) begin
            #1;
            if (pc_ready) begin
                acc++;
                @(negedge clk);
                if (acc < 3) pc_addr = pc_addr + 32'd4;
                else pc_valid = 1'b0;
                #1 check("b2b_wait_pc_ready", {31'd0, pc_ready}, 32'd0);
            end
            @(negedge clk);
        end
        check("b2b_accepts", acc, 32'd3);
        repeat (3) @(negedge clk);
        check("b2b_drained", exp_q.size(), 32'd0);
        check("b2b_pops", pops, 32'd4);

        // Flush in WAIT: late 0xDEADBEEF must be dropped
        lat = 3;
        pc_addr = 32'h300; pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("flush_wait_ir_valid", {31'd0, ir_valid}, 32'd0);
            @(negedge clk);
        end
        check("flush_wait_ir_valid_after", {31'd0, ir_valid}, 32'd0);
        #1 check("flush_wait_idle", {31'd0, pc_ready}, 32'd1);
        lat = 0;
        pc_addr = 32'h200; pc_valid = 1'b1;
        expect_ir(32'h200, mem_word(32'h200));
        @(negedge clk);
        pc_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("refetch_drained", exp_q.size(), 32'd0);

        // Flush in HOLD
        ir_ready = 1'b0;
        pc_addr = 32'h400; pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        @(negedge clk);
        check("hold_before_flush", {31'd0, ir_valid}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_hold_ir_valid", {31'd0, ir_valid}, 32'd0);
        #1 check("flush_hold_idle", {31'd0, pc_ready}, 32'd1);

        // Flush together with the response: back to IDLE, not DRAIN
        @(negedge clk);
        pc_addr = 32'h500; pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_rvalid_ir_valid", {31'd0, ir_valid}, 32'd0);
        #1 check("flush_rvalid_idle", {31'd0, pc_ready}, 32'd1);

        // Timeout with TIMEOUT=8
        @(negedge clk);
        resp_off = 1'b1;
        pc_addr = 32'h600; pc_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            pc_valid = 1'b0;
            check("timeout_fault_early", {31'd0, fault}, 32'd0);
        end
        @(negedge clk);
        check("timeout_fault", {31'd0, fault}, 32'd1);
        check("timeout_ir_valid", {31'd0, ir_valid}, 32'd0);
        #1 check("timeout_idle", {31'd0, pc_ready}, 32'd1);
        @(negedge clk);
        check("fault_sticky", {31'd0, fault}, 32'd1);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        check("fault_cleared", {31'd0, fault}, 32'd0);
        resp_off = 1'b0;

        // Asynchronous reset mid-WAIT; the pending response arrives later
        lat = 3;
        pc_addr = 32'h700; pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        check("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_mem_req", {31'd0, mem_req}, 32'd0);
        check("arst_mem_addr", mem_addr, 32'd0);
        check("arst_ir", ir, 32'd0);
        check("arst_ir_addr", ir_addr, 32'd0);
        check("arst_ir_valid", {31'd0, ir_valid}, 32'd0);
        #1 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("late_rvalid_ir_valid", {31'd0, ir_valid}, 32'd0);
        end
        check("late_rvalid_ir", ir, 32'd0);

        // Misaligned PC
        lat = 0; ir_ready = 1'b1;
        pc_addr = 32'h102; pc_valid = 1'b1;
        #1 check("misalign_pc_ready", {31'd0, pc_ready}, 32'd1);
`ifdef OTTER_IFETCH_ALIGN_CHECK_EN
        @(negedge clk);
        pc_valid = 1'b0;
        check("misalign_no_req", {31'd0, mem_req}, 32'd0);
        check("misalign_fault", {31'd0, fault}, 32'd1);
        check("misalign_ir_valid", {31'd0, ir_valid}, 32'd0);
        #1 check("misalign_idle", {31'd0, pc_ready}, 32'd1);
`else
        expect_ir(32'h100, 32'h0050_0093);
        @(negedge clk);
        pc_valid = 1'b0;
        check("align_mem_req", {31'd0, mem_req}, 32'd1);
        check("align_mem_addr", mem_addr, 32'h100);
`endif
        repeat (4) @(negedge clk);
        check("final_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/otter_ifetch.md
OTTER_IFETCH -- requirements
Module: otter_ifetch

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 64: the number of cycles to wait for mem_rvalid before flagging a bus fault (range 2..65535).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port pc_addr, input, 32 bits: the fetch address from the program counter.
REQ-005 The block SHALL have port pc_valid, input, 1 bit: pc_addr is a valid fetch request.
REQ-006 The block SHALL have port pc_ready, output, 1 bit: a request is accepted this cycle; drives the PC write enable.
REQ-007 The block SHALL have port flush, input, 1 bit: discard any in-flight or held instruction (branch redirect).
REQ-008 The block SHALL have ports mem_req (output, 1 bit) and mem_addr (output, 32 bits): the instruction memory read request and its address.
REQ-009 The block SHALL have ports mem_rvalid (input, 1 bit) and mem_rdata (input, 32 bits): the read response strobe and its data.
REQ-010 The block SHALL have ports ir (output, 32 bits), ir_addr (output, 32 bits) and ir_valid (output, 1 bit): the fetched instruction, its address, and its valid flag.
REQ-011 The block SHALL have port ir_ready, input, 1 bit: the decode stage consumes ir this cycle when it is high together with ir_valid.
REQ-012 The block SHALL have port fault, output, 1 bit: a sticky fetch-fault flag.
REQ-013 The block SHALL have port fault_clr, input, 1 bit: clears fault.

Function
REQ-014 The block SHALL implement four states: IDLE, WAIT, HOLD, DRAIN.
REQ-015 In IDLE, pc_ready SHALL be 1, and pc_valid=1 SHALL register pc_addr into mem_addr and ir_addr, assert mem_req for exactly one cycle (the next cycle), and enter WAIT.
REQ-016 In WAIT, mem_rvalid=1 SHALL capture mem_rdata into ir, set ir_valid=1 the following cycle, and enter HOLD; the minimum latency from pc_valid to ir_valid SHALL be 2 cycles.
REQ-017 In HOLD, ir, ir_addr and ir_valid SHALL remain stable until ir_ready=1.
REQ-018 In HOLD, ir_ready=1 SHALL clear ir_valid; if pc_valid is also 1, pc_ready SHALL be 1 and the next fetch SHALL issue back-to-back (go to WAIT), otherwise the block SHALL go to IDLE.
REQ-019 pc_ready SHALL be 0 in WAIT and DRAIN, and SHALL be 0 in HOLD unless ir_ready=1.
REQ-020 Flush in HOLD SHALL clear ir_valid and go to IDLE.
REQ-021 Flush in WAIT SHALL go to DRAIN; the next mem_rvalid SHALL be discarded and the block SHALL return to IDLE.
REQ-022 Flush in the same cycle as mem_rvalid in WAIT SHALL discard the data and go to IDLE.
REQ-023 Flush in IDLE SHALL be ignored, and flush SHALL take priority over pc_valid in that cycle.
REQ-024 A 16-bit wait counter SHALL clear on entry to WAIT or DRAIN and increment each cycle without mem_rvalid, saturating at 65535.
REQ-025 A count reaching TIMEOUT-1 without mem_rvalid SHALL set fault, and the block SHALL go to IDLE with ir_valid=0.
REQ-026 fault SHALL hold until fault_clr=1; fault_clr SHALL lose to a fault set in the same cycle.
REQ-027 A mem_rvalid arriving in IDLE or HOLD SHALL be ignored.

Reset
REQ-028 Asserting rst SHALL immediately force state=IDLE, mem_req=0, mem_addr=0, ir=0, ir_addr=0, ir_valid=0, fault=0 and counter=0, including mid-WAIT.
REQ-029 pc_ready SHALL read 1 while in IDLE after reset release.
REQ-030 A response arriving after a mid-WAIT reset SHALL be ignored.

Configuration
REQ-031 With OTTER_IFETCH_ALIGN_CHECK_EN defined, pc_valid with pc_addr[1:0]!=0 SHALL be accepted (pc_ready=1) but SHALL NOT raise mem_req; it SHALL set fault, keep ir_valid=0, and stay in IDLE.
REQ-032 Without OTTER_IFETCH_ALIGN_CHECK_EN, pc_addr[1:0] SHALL be ignored and mem_addr SHALL be driven as {pc_addr[31:2],2'b00}.

Verification
REQ-033 Single fetch: pc_addr=0x100 with pc_valid, memory answering after 1 cycle with 0x00500093 -> ir=0x00500093, ir_addr=0x100, ir_valid=1 at cycle 2; ir stable while ir_ready=0.
REQ-034 Back-to-back: pc_valid held at 0x0, 0x4, 0x8 with ir_ready=1 and 1-cycle memory -> three instructions in order, no duplicates, pc_ready pulses once per instruction.
REQ-035 Flush in WAIT: flush the cycle after mem_req, memory answers 3 cycles later with 0xDEADBEEF -> ir_valid never rises, block returns to IDLE, and the next fetch of 0x200 returns correct data.
REQ-036 Timeout: TIMEOUT=8, mem_rvalid never asserted -> fault=1 eight cycles after entering WAIT, state IDLE; fault_clr=1 -> fault=0.
REQ-037 Async reset mid-WAIT: rst pulsed between clock edges -> all outputs zero immediately; a late mem_rvalid is ignored.
REQ-038 Alignment (macro defined): pc_addr=0x102 -> mem_req stays 0 and fault=1; with the macro undefined -> mem_addr=0x100.
